// File: rtl/mul_pkg.sv
// Shared definitions for the arbitrated repeated-addition multiplier controller.
//   StateW   : width of the controller state register
//   DefaultW : default operand/product width
//   state_e  : controller state encoding (IDLE, LDA, LDB, ACC, DONE)
package mul_pkg;

  localparam int unsigned StateW   = 3;
  localparam int unsigned DefaultW = 16;

  typedef enum logic [StateW-1:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin pick: the first set request bit at or above
// the pointer, wrapping around to bit 0.
//   req_i   : per-requester request bits
//   ptr_i   : index with highest priority this cycle
//   gnt_o   : one-hot grant (all zero when no request)
//   id_o    : encoded index of the granted requester
//   valid_o : at least one request present
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] id_o,
  output logic           valid_o
);

  int unsigned idx;

  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!valid_o && req_i[idx]) begin
        valid_o    = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/mul_arbiter_ctrl.sv
// Shares one repeated-addition multiplier datapath between N requesters.
// A round-robin arbiter picks a requester in IDLE; the FSM then loads A, loads B
// and clears P, accumulates until the B counter reaches zero, and returns the
// product tagged with the requester id.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   req, op_a, op_b      : per-requester request level and packed operands
//   gnt                  : one-hot 1-cycle grant; operands sampled that cycle
//   busy                 : job in flight (after gnt through rsp_valid)
//   rsp_valid/rsp_id     : 1-cycle response pulse and owning requester index
//   product              : A*B mod 2^W, held until the next response
//   dp_data, ldA, ldB, ldP, clrP, decB : datapath data/control
//   eqZ, dp_pout         : datapath B-counter zero flag and product register
// Build option: OPERAND_SWAP_EN puts the larger operand in A and the smaller
// in the B counter, so accumulation takes min(A,B) cycles.
module mul_arbiter_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = DefaultW,
  parameter int unsigned IdW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] op_a,
  input  logic [N*W-1:0] op_b,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           rsp_valid,
  output logic [IdW-1:0] rsp_id,
  output logic [W-1:0]   product,
  output logic [W-1:0]   dp_data,
  output logic           ldA,
  output logic           ldB,
  output logic           ldP,
  output logic           clrP,
  output logic           decB,
  input  logic           eqZ,
  input  logic [W-1:0]   dp_pout
);

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [IdW-1:0] id_q, id_d;
  logic [W-1:0]   product_q, product_d;
  logic [IdW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic [N-1:0]   arb_gnt;
  logic [IdW-1:0] arb_id;
  logic           arb_valid;
  logic [W-1:0]   sel_a, sel_b;

  rr_arbiter #(
    .N   (N),
    .IdW (IdW)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .id_o    (arb_id),
    .valid_o (arb_valid)
  );

  // One-hot mux of the granted requester's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_a = sel_a | (op_a[i*W +: W] & {W{arb_gnt[i]}});
      sel_b = sel_b | (op_b[i*W +: W] & {W{arb_gnt[i]}});
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    product_d   = product_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = 1'b0;
    // Gated by rst so every output reads 0 while reset is held.
    gnt         = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid && !rst) begin
          gnt   = arb_gnt;
          a_d   = sel_a;
          b_d   = sel_b;
`ifdef OPERAND_SWAP_EN
          if (sel_b > sel_a) begin
            a_d = sel_b;
            b_d = sel_a;
          end
`endif
          id_d    = arb_id;
          ptr_d   = (arb_id == IdW'(N - 1)) ? '0 : arb_id + IdW'(1);
          state_d = LDA;
        end
      end
      LDA: state_d = LDB;
      LDB: state_d = ACC;
      ACC: begin
        // P is final once eqZ is seen; capture here so product and rsp_id
        // are already valid in the DONE cycle alongside rsp_valid.
        if (eqZ) begin
          product_d   = dp_pout;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      product_q   <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      product_q   <= product_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Datapath controls decode straight from the state register; ldP/decB also
  // need eqZ so the counter never decrements past zero.
  always_comb begin
    dp_data = '0;
    ldA     = 1'b0;
    ldB     = 1'b0;
    clrP    = 1'b0;
    ldP     = 1'b0;
    decB    = 1'b0;
    unique case (state_q)
      LDA: begin
        dp_data = a_q;
        ldA     = 1'b1;
      end
      LDB: begin
        dp_data = b_q;
        ldB     = 1'b1;
        clrP    = 1'b1;
      end
      ACC: begin
        ldP  = !eqZ;
        decB = !eqZ;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign product   = product_q;

endmodule

// File: tb/tb_mul_arbiter_ctrl.sv
module tb_mul_arbiter_ctrl;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int Limit = 1200;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b;
  logic [N-1:0]   gnt;
  logic           busy, rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   product, dp_data;
  logic           ldA, ldB, ldP, clrP, decB, eqZ;
  logic [W-1:0]   dp_pout;

  always #5 clk = ~clk;

  mul_arbiter_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .product   (product),
    .dp_data   (dp_data),
    .ldA       (ldA),
    .ldB       (ldB),
    .ldP       (ldP),
    .clrP      (clrP),
    .decB      (decB),
    .eqZ       (eqZ),
    .dp_pout   (dp_pout)
  );

  // Behavioural repeated-addition datapath.
  logic [W-1:0] dp_a, dp_b, dp_p;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a <= '0;
      dp_b <= '0;
      dp_p <= '0;
    end else begin
      if (ldA) dp_a <= dp_data;
      if (ldB) dp_b <= dp_data;
      else if (decB) dp_b <= dp_b - 16'd1;
      if (clrP) dp_p <= '0;
      else if (ldP) dp_p <= dp_p + dp_a;
    end
  end
  assign eqZ     = (dp_b == '0);
  assign dp_pout = dp_p;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int ctrl_viol = 0;
  int acc_cnt   = 0;
  int mptr      = 0;
  int order_q[$];
  logic [W-1:0] av[N];
  logic [W-1:0] bv[N];

  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] prod;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    total++;
    $display("FAIL %s: got timeout expected event within %0d cycles", nm, Limit);
  endtask

  task automatic tick();
    int groups;
    @(negedge clk);
    cyc++;
    groups = int'(ldA) + int'(ldB | clrP) + int'(ldP | decB);
    if (groups > 1 || ((ldP | decB) && eqZ)) ctrl_viol++;
    if (ldP | decB) acc_cnt++;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i*W +: W] = av[i];
      op_b[i*W +: W] = bv[i];
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  function automatic int acc_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef OPERAND_SWAP_EN
    return (a < b) ? int'(a) : int'(b);
`else
    return int'(b);
`endif
  endfunction

  // Hold the masked requests until each is granted; check every grant and response.
  task automatic serve(input logic [N-1:0] mask, input string tag);
    logic [N-1:0] m;
    logic [N-1:0] eg;
    logic [31:0]  full;
    int e, t, got, acc0;
    bit ok;
    m = mask;
    req = m;
    drive_ops();
    while (m != '0) begin
      e  = pick(m, mptr);
      ok = 0;
      for (int k = 0; k < Limit; k++) begin
        #1;
        if (gnt != '0) begin
          ok = 1;
          break;
        end
        tick();
      end
      if (!ok) begin
        timeout({tag, ".gnt"});
        req = '0;
        return;
      end
      eg = '0;
      eg[e] = 1'b1;
      chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
      chk({tag, ".busy_at_gnt"}, 32'(busy), 0);
      got = e;
      for (int i = 0; i < N; i++) if (gnt[i]) got = i;
      order_q.push_back(got);
      t    = cyc;
      acc0 = acc_cnt;
      full = 32'(av[e]) * 32'(bv[e]);
      tick();
      m[e] = 1'b0;
      req  = m;
      mptr = (e + 1) % N;
      ok = 0;
      for (int k = 0; k < Limit; k++) begin
        if (rsp_valid) begin
          ok = 1;
          break;
        end
        tick();
      end
      if (!ok) begin
        timeout({tag, ".rsp"});
        req = '0;
        return;
      end
      chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(e));
      chk({tag, ".product"}, 32'(product), 32'(full[W-1:0]));
      chk({tag, ".latency"}, 32'(cyc - t), 32'(acc_cycles(av[e], bv[e]) + 4));
      chk({tag, ".acc_cycles"}, 32'(acc_cnt - acc0), 32'(acc_cycles(av[e], bv[e])));
      chk({tag, ".busy_at_rsp"}, 32'(busy), 1);
    end
  endtask

  task automatic clear_ops();
    for (int i = 0; i < N; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
  endtask

  initial begin
    logic [N-1:0] mask;
    int rv_cnt;
    bit ok;

    vt[0] = '{id: 0, a: 16'd17,    b: 16'd5,    prod: 16'd85};
    vt[1] = '{id: 2, a: 16'd123,   b: 16'd0,    prod: 16'd0};
    vt[2] = '{id: 1, a: 16'd300,   b: 16'd300,  prod: 16'd24464};
    vt[3] = '{id: 0, a: 16'd3,     b: 16'd1000, prod: 16'd3000};
    vt[4] = '{id: 3, a: 16'hFFFF,  b: 16'd2,    prod: 16'hFFFE};
    vt[5] = '{id: 1, a: 16'd0,     b: 16'd9,    prod: 16'd0};

    rst = 1'b1;
    req = '0;
    clear_ops();
    drive_ops();
    #1;
    chk("reset.ctrl", 32'({gnt, busy, rsp_valid, rsp_id, ldA, ldB, ldP, clrP, decB}), 0);
    chk("reset.data", {product, dp_data}, 0);
    tick();
    tick();
    rst = 1'b0;

    // Single-requester vectors.
    for (int i = 0; i < 6; i++) begin
      clear_ops();
      av[vt[i].id] = vt[i].a;
      bv[vt[i].id] = vt[i].b;
      mask = '0;
      mask[vt[i].id] = 1'b1;
      serve(mask, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.table_product", i), 32'(product), 32'(vt[i].prod));
    end

    // Random multi-requester rounds checked against the round-robin model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        av[i] = W'($urandom);
        bv[i] = W'($urandom_range(0, 12));
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      serve(mask, $sformatf("rnd%0d", r));
    end

    // Reset in the third accumulate cycle drops the job.
    clear_ops();
    av[0] = 16'd7;
    bv[0] = 16'd10;
    req = 4'b0001;
    drive_ops();
    ok = 0;
    for (int k = 0; k < Limit; k++) begin
      #1;
      if (gnt != '0) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) timeout("rst_mid.gnt");
    tick();
    req = '0;
    repeat (4) tick();
    chk("rst_mid.in_acc", 32'(ldP), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.ctrl", 32'({gnt, busy, rsp_valid, rsp_id, ldA, ldB, ldP, clrP, decB}), 0);
    chk("rst_mid.data", {product, dp_data}, 0);
    tick();
    rst  = 1'b0;
    mptr = 0;
    rv_cnt = 0;
    repeat (20) begin
      tick();
      if (rsp_valid) rv_cnt++;
    end
    chk("rst_mid.no_rsp", 32'(rv_cnt), 0);
    clear_ops();
    av[3] = 16'd2;
    bv[3] = 16'd3;
    serve(4'b1000, "after_rst");
    chk("after_rst.product", 32'(product), 6);

    // All four request together: served 0,1,2,3.
    for (int i = 0; i < N; i++) begin
      av[i] = W'(5 + i);
      bv[i] = W'(1 + i);
    end
    order_q.delete();
    serve(4'b1111, "all4");
    for (int i = 0; i < N; i++) begin
      if (i < order_q.size()) chk($sformatf("all4.order%0d", i), 32'(order_q[i]), 32'(i));
      else timeout($sformatf("all4.order%0d", i));
    end

    chk("ctrl_exclusive", 32'(ctrl_viol), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
